data_table_rr_arb: RTL and testbench
====================================

Name: data_table_rr_arb

Overview:
- Parametrised arbitrating multiplexer between DIR_CNT data-table clients and one data-table RAM port pair (read port, write port).
- Fixed "last index wins" selection replaced by independent round-robin arbiters for reads and writes with explicit grants.
- Read returns are routed back to the requester via a latency-matched tag pipeline.
- Sits between the hash-table engines (search/insert/delete) and the data table RAM.

Parameters:
- DIR_CNT, 4, number of client directions (>=1).
- A_WIDTH, 10, data-table address width.
- D_WIDTH, 64, data-table word width (flattened ram_data_t).
- RD_LATENCY, 2, RAM cycles from out_rd_en_o to valid out_rd_data_i (>=1).

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- in_rd_addr_i  input  DIR_CNT*A_WIDTH  per-client read address; client i at bits [i*A_WIDTH +: A_WIDTH].
- in_rd_en_i  input  DIR_CNT  per-client read request.
- in_rd_gnt_o  output  DIR_CNT  one-hot read grant (combinational).
- in_rd_data_o  output  D_WIDTH  read data, broadcast to all clients.
- in_rd_val_o  output  DIR_CNT  one-hot: in_rd_data_o belongs to client i.
- in_wr_addr_i  input  DIR_CNT*A_WIDTH  per-client write address.
- in_wr_data_i  input  DIR_CNT*D_WIDTH  per-client write data.
- in_wr_en_i  input  DIR_CNT  per-client write request.
- in_wr_gnt_o  output  DIR_CNT  one-hot write grant (combinational).
- out_rd_addr_o  output  A_WIDTH  RAM read address (registered).
- out_rd_en_o  output  1  RAM read enable (registered).
- out_rd_data_i  input  D_WIDTH  RAM read data.
- out_wr_addr_o  output  A_WIDTH  RAM write address (registered).
- out_wr_data_o  output  D_WIDTH  RAM write data (registered).
- out_wr_en_o  output  1  RAM write enable (registered).

Behaviour:
- Reset:
  - One clock (clk_i); reset rst_n_i is asynchronous and active-low.
  - During reset: all registered outputs 0, rd/wr priority pointers 0, tag pipeline cleared.
  - Hence in_rd_val_o = 0 and out_*_en_o = 0.
- Handshake:
  - Client i holds en and addr/data stable until the cycle gnt[i]=1; the transfer occurs in that cycle.
  - gnt depends combinationally on en and the pointer only; never on out_rd_data_i.
- Round-robin arbitration (read and write arbiters identical and independent):
  - Search starts at pointer p and goes upward modulo DIR_CNT; the first asserted en is granted.
  - On a grant to k, pointer <= (k+1) mod DIR_CNT.
  - No request: pointer holds, gnt = 0.
  - DIR_CNT=1: pointer is constant 0 and the grant equals en.
- Grant cycle: selected address/data are registered into out_*; out_*_en_o = 1 in the next cycle, otherwise 0. Grant-to-RAM latency is 1 cycle.
- Read tag pipeline:
  - Depth RD_LATENCY+1; stores the one-hot read grant.
  - in_rd_val_o = pipeline tail; exactly RD_LATENCY+1 cycles after the grant cycle.
  - in_rd_data_o = out_rd_data_i (combinational pass-through).
- Throughput: one read and one write accepted per cycle, simultaneously, including same address. No RAW ordering inside this block; the RAM defines same-address read/write semantics.
- Reset mid-operation: in-flight reads are discarded with no in_rd_val_o. Clients must reissue.
- All outputs are a deterministic function of registered state and current inputs; no X when en = 0.

Optional Feature:
- Macro DATA_TABLE_RR_ARB_STATS_EN.
- Defined: adds outputs stat_rd_cnt_o and stat_wr_cnt_o (DIR_CNT*32 each), plus stat_rd_stall_o and stat_wr_stall_o (32 each).
  - Per-client grant counters increment on gnt.
  - Stall counters increment each cycle with at least 1 en not granted.
  - All counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: no counters and no stat ports; function otherwise identical.

Test Plan:
- Reset, then idle 10 cycles -> all grants/val/en outputs 0; out_rd_addr_o = 0.
- Client 2 reads addr 0x15 (RD_LATENCY=2), RAM returns 0xDEAD at the correct cycle -> gnt[2] at T, out_rd_en_o at T+1 with addr 0x15, in_rd_val_o = 0b0100 at T+3 with data 0xDEAD.
- All 4 clients hold in_rd_en_i for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; one grant/cycle; in_rd_val_o order matches.
- Clients 1 and 3 request writes (0x7 <- 0xA5, 0x9 <- 0x5A) while client 0 reads 0x7 in the same cycle -> read gnt[0] and write gnt[1] same cycle; the write of 0x9 goes to out_wr on the following cycle; pointer advances to 2 then to 0.
- Reads granted at T and T+1, rst_n_i low at T+2 -> no in_rd_val_o for either; pointers 0 after release.
- With DATA_TABLE_RR_ARB_STATS_EN defined, 3 clients read continuously for 9 cycles -> stat_rd_cnt_o = 3 per active client, stat_rd_stall_o = 9.

Source files
------------

// File: rtl/data_table_rr_arb_if.sv
// Client/RAM bus bundle for data_table_rr_arb.
// slave  : the arbiter side (consumes client requests and RAM read data).
// master : the environment side (clients plus the data-table RAM).
interface data_table_rr_arb_if #(
  parameter int DIR_CNT = 4,
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 64
);
  logic [DIR_CNT*A_WIDTH-1:0] in_rd_addr_i;
  logic [DIR_CNT-1:0]         in_rd_en_i;
  logic [DIR_CNT-1:0]         in_rd_gnt_o;
  logic [D_WIDTH-1:0]         in_rd_data_o;
  logic [DIR_CNT-1:0]         in_rd_val_o;
  logic [DIR_CNT*A_WIDTH-1:0] in_wr_addr_i;
  logic [DIR_CNT*D_WIDTH-1:0] in_wr_data_i;
  logic [DIR_CNT-1:0]         in_wr_en_i;
  logic [DIR_CNT-1:0]         in_wr_gnt_o;
  logic [A_WIDTH-1:0]         out_rd_addr_o;
  logic                       out_rd_en_o;
  logic [D_WIDTH-1:0]         out_rd_data_i;
  logic [A_WIDTH-1:0]         out_wr_addr_o;
  logic [D_WIDTH-1:0]         out_wr_data_o;
  logic                       out_wr_en_o;

  modport slave (
    input  in_rd_addr_i, in_rd_en_i, in_wr_addr_i, in_wr_data_i, in_wr_en_i, out_rd_data_i,
    output in_rd_gnt_o, in_rd_data_o, in_rd_val_o, in_wr_gnt_o,
    output out_rd_addr_o, out_rd_en_o, out_wr_addr_o, out_wr_data_o, out_wr_en_o
  );

  modport master (
    output in_rd_addr_i, in_rd_en_i, in_wr_addr_i, in_wr_data_i, in_wr_en_i, out_rd_data_i,
    input  in_rd_gnt_o, in_rd_data_o, in_rd_val_o, in_wr_gnt_o,
    input  out_rd_addr_o, out_rd_en_o, out_wr_addr_o, out_wr_data_o, out_wr_en_o
  );
endinterface

// File: rtl/data_table_rr_arb.sv
// Round-robin arbitrating mux between DIR_CNT data-table clients and one
// data-table RAM read/write port pair. Reads and writes have independent
// arbiters; read returns are steered back by a latency-matched tag pipeline.
// Optional grant/stall counters: define DATA_TABLE_RR_ARB_STATS_EN.
//
// Handshake: a client raises en[i] with addr/data and holds all of them
// stable until the cycle gnt[i]=1; the transfer happens in that cycle. gnt is
// a combinational function of en and the arbiter pointer only. The RAM sees
// the selected request one cycle later; the read result is flagged to the
// requester on in_rd_val_o RD_LATENCY+1 cycles after its grant cycle.
module data_table_rr_arb #(
  parameter int DIR_CNT    = 4,
  parameter int A_WIDTH    = 10,
  parameter int D_WIDTH    = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  data_table_rr_arb_if.slave   bus
`ifdef DATA_TABLE_RR_ARB_STATS_EN
  ,
  output logic [DIR_CNT*32-1:0] stat_rd_cnt_o,
  output logic [DIR_CNT*32-1:0] stat_wr_cnt_o,
  output logic [31:0]           stat_rd_stall_o,
  output logic [31:0]           stat_wr_stall_o
`endif
);

  localparam int PTR_W = (DIR_CNT > 1) ? $clog2(DIR_CNT) : 1;

  // First requester at or above ptr, otherwise wrap to the lowest requester.
  function automatic logic [DIR_CNT-1:0] rr_pick(input logic [DIR_CNT-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [DIR_CNT-1:0] hi_req;
    logic [DIR_CNT-1:0] pick;
    logic               found;
    hi_req = '0;
    pick   = '0;
    found  = 1'b0;
    for (int i = 0; i < DIR_CNT; i++) hi_req[i] = req[i] && (i >= int'(ptr));
    for (int i = 0; i < DIR_CNT; i++) begin
      if (!found && hi_req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < DIR_CNT; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pointer moves just past the granted client; holds when nothing is granted.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [DIR_CNT-1:0] gnt,
                                                input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] res;
    res = ptr;
    for (int i = 0; i < DIR_CNT; i++) begin
      if (gnt[i]) res = (i == DIR_CNT - 1) ? '0 : PTR_W'(i + 1);
    end
    return res;
  endfunction

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DIR_CNT-1:0] rd_gnt, wr_gnt;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [DIR_CNT-1:0] tag_q [RD_LATENCY+1];
  logic [DIR_CNT-1:0] tag_d [RD_LATENCY+1];

  // Arbitration, request muxing and tag pipeline next state.
  always_comb begin
    rd_gnt    = rr_pick(bus.in_rd_en_i, rd_ptr_q);
    wr_gnt    = rr_pick(bus.in_wr_en_i, wr_ptr_q);
    rd_ptr_d  = next_ptr(rd_gnt, rd_ptr_q);
    wr_ptr_d  = next_ptr(wr_gnt, wr_ptr_q);
    rd_en_d   = |rd_gnt;
    wr_en_d   = |wr_gnt;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (rd_en_d) begin
      rd_addr_d = '0;
      for (int i = 0; i < DIR_CNT; i++)
        if (rd_gnt[i]) rd_addr_d = rd_addr_d | bus.in_rd_addr_i[i*A_WIDTH +: A_WIDTH];
    end
    if (wr_en_d) begin
      wr_addr_d = '0;
      wr_data_d = '0;
      for (int i = 0; i < DIR_CNT; i++) begin
        if (wr_gnt[i]) begin
          wr_addr_d = wr_addr_d | bus.in_wr_addr_i[i*A_WIDTH +: A_WIDTH];
          wr_data_d = wr_data_d | bus.in_wr_data_i[i*D_WIDTH +: D_WIDTH];
        end
      end
    end
    tag_d[0] = rd_gnt;
    for (int i = 1; i <= RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // State registers; reset also discards every in-flight read tag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      for (int i = 0; i <= RD_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign bus.in_rd_gnt_o   = rd_gnt;
  assign bus.in_wr_gnt_o   = wr_gnt;
  assign bus.in_rd_data_o  = bus.out_rd_data_i;
  assign bus.in_rd_val_o   = tag_q[RD_LATENCY];
  assign bus.out_rd_addr_o = rd_addr_q;
  assign bus.out_rd_en_o   = rd_en_q;
  assign bus.out_wr_addr_o = wr_addr_q;
  assign bus.out_wr_data_o = wr_data_q;
  assign bus.out_wr_en_o   = wr_en_q;

`ifdef DATA_TABLE_RR_ARB_STATS_EN
  logic [31:0] rd_cnt_q [DIR_CNT];
  logic [31:0] rd_cnt_d [DIR_CNT];
  logic [31:0] wr_cnt_q [DIR_CNT];
  logic [31:0] wr_cnt_d [DIR_CNT];
  logic [31:0] rd_stall_q, rd_stall_d, wr_stall_q, wr_stall_d;

  // Saturating grant and stall counters.
  always_comb begin
    for (int i = 0; i < DIR_CNT; i++) begin
      rd_cnt_d[i] = (rd_gnt[i] && (rd_cnt_q[i] != '1)) ? rd_cnt_q[i] + 32'd1 : rd_cnt_q[i];
      wr_cnt_d[i] = (wr_gnt[i] && (wr_cnt_q[i] != '1)) ? wr_cnt_q[i] + 32'd1 : wr_cnt_q[i];
    end
    rd_stall_d = ((|(bus.in_rd_en_i & ~rd_gnt)) && (rd_stall_q != '1)) ? rd_stall_q + 32'd1 : rd_stall_q;
    wr_stall_d = ((|(bus.in_wr_en_i & ~wr_gnt)) && (wr_stall_q != '1)) ? wr_stall_q + 32'd1 : wr_stall_q;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DIR_CNT; i++) begin
        rd_cnt_q[i] <= '0;
        wr_cnt_q[i] <= '0;
      end
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      for (int i = 0; i < DIR_CNT; i++) begin
        rd_cnt_q[i] <= rd_cnt_d[i];
        wr_cnt_q[i] <= wr_cnt_d[i];
      end
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  for (genvar gi = 0; gi < DIR_CNT; gi++) begin : g_stat
    assign stat_rd_cnt_o[gi*32 +: 32] = rd_cnt_q[gi];
    assign stat_wr_cnt_o[gi*32 +: 32] = wr_cnt_q[gi];
  end
  assign stat_rd_stall_o = rd_stall_q;
  assign stat_wr_stall_o = wr_stall_q;
`endif

endmodule

// File: tb/tb_data_table_rr_arb.sv
// Bench for data_table_rr_arb: directed scenarios plus randomized client
// traffic, checked every cycle against a behavioural arbiter/RAM model.
module tb_data_table_rr_arb;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_table_rr_arb_if #(.DIR_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW)) bus ();

`ifdef DATA_TABLE_RR_ARB_STATS_EN
  logic [N*32-1:0] stat_rd_cnt, stat_wr_cnt;
  logic [31:0]     stat_rd_stall, stat_wr_stall;
`endif

  data_table_rr_arb #(.DIR_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RD_LATENCY(LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
`ifdef DATA_TABLE_RR_ARB_STATS_EN
    ,
    .stat_rd_cnt_o   (stat_rd_cnt),
    .stat_wr_cnt_o   (stat_wr_cnt),
    .stat_rd_stall_o (stat_rd_stall),
    .stat_wr_stall_o (stat_wr_stall)
`endif
  );

  // ---------------- RAM model: fixed contents, LAT-cycle read ----------------
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ram_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= mem[bus.out_rd_addr_o];
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.out_rd_data_i = ram_pipe[LAT-1];

  // ---------------- client state ----------------
  logic [N-1:0]  rd_pend, wr_pend;
  logic [AW-1:0] rd_a [N];
  logic [AW-1:0] wr_a [N];
  logic [DW-1:0] wr_d [N];

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int            due;
    int            client;
    logic [AW-1:0] addr;
  } ret_t;
  ret_t          ret_q [$];
  logic [AW-1:0] exp_q [$];   // granted read addresses, in grant order
  int            rd_ptr_m, wr_ptr_m, cyc;
  logic          m_rd_en, m_wr_en;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [DW-1:0] m_wr_data;
  int            m_rd_cnt [N];
  int            m_wr_cnt [N];
  int            m_rd_stall, m_wr_stall;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester closest to ptr going upward (mod N) wins; -1 if none.
  function automatic int rr_model(input logic [N-1:0] req, input int ptr);
    int best, best_d, d;
    best   = -1;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - ptr + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_rd_addr_i[i*AW +: AW] = rd_a[i];
      bus.in_wr_addr_i[i*AW +: AW] = wr_a[i];
      bus.in_wr_data_i[i*DW +: DW] = wr_d[i];
    end
    bus.in_rd_en_i = rd_pend;
    bus.in_wr_en_i = wr_pend;
  endtask

  task automatic model_reset();
    rd_ptr_m = 0; wr_ptr_m = 0;
    m_rd_en = 1'b0; m_wr_en = 1'b0;
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
    ret_q.delete();
    exp_q.delete();
    m_rd_stall = 0; m_wr_stall = 0;
    for (int i = 0; i < N; i++) begin
      m_rd_cnt[i] = 0;
      m_wr_cnt[i] = 0;
    end
  endtask

  // Called at posedge+1; holds reset for one full clock.
  task automatic do_reset();
    rst_n   = 1'b0;
    rd_pend = '0;
    wr_pend = '0;
    drive();
    model_reset();
    #2;
    check_eq("rst_rd_val",  bus.in_rd_val_o, '0);
    check_eq("rst_rd_en",   bus.out_rd_en_o, 1'b0);
    check_eq("rst_wr_en",   bus.out_wr_en_o, 1'b0);
    check_eq("rst_rd_addr", bus.out_rd_addr_o, '0);
    check_eq("rst_rd_gnt",  bus.in_rd_gnt_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison at negedge, then model update.
  task automatic check_cycle();
    int            kr, kw;
    logic [N-1:0]  er, ew, ev;
    logic [DW-1:0] ed;
    ret_t          r;
    kr = rr_model(bus.in_rd_en_i, rd_ptr_m);
    kw = rr_model(bus.in_wr_en_i, wr_ptr_m);
    er = '0; if (kr >= 0) er[kr] = 1'b1;
    ew = '0; if (kw >= 0) ew[kw] = 1'b1;
    check_eq("rd_gnt", bus.in_rd_gnt_o, er);
    check_eq("wr_gnt", bus.in_wr_gnt_o, ew);
    check_eq("out_rd_en", bus.out_rd_en_o, m_rd_en);
    check_eq("out_wr_en", bus.out_wr_en_o, m_wr_en);
    if (m_rd_en) check_eq("out_rd_addr", bus.out_rd_addr_o, m_rd_addr);
    if (m_wr_en) begin
      check_eq("out_wr_addr", bus.out_wr_addr_o, m_wr_addr);
      check_eq("out_wr_data", bus.out_wr_data_o, m_wr_data);
    end
    ev = '0;
    ed = '0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      ev[r.client] = 1'b1;
      ed = mem[r.addr];
      check_eq("ret_order", r.addr, exp_q.pop_front());
    end
    check_eq("rd_val", bus.in_rd_val_o, ev);
    if (ev != '0) check_eq("rd_data", bus.in_rd_data_o, ed);
    // model update for the transfers of this cycle
    if ((bus.in_rd_en_i & ~er) != '0) m_rd_stall++;
    if ((bus.in_wr_en_i & ~ew) != '0) m_wr_stall++;
    m_rd_en = (kr >= 0);
    m_wr_en = (kw >= 0);
    if (kr >= 0) begin
      m_rd_addr = rd_a[kr];
      rd_ptr_m  = (kr + 1) % N;
      ret_q.push_back('{cyc + LAT + 1, kr, rd_a[kr]});
      exp_q.push_back(rd_a[kr]);
      rd_pend[kr] = 1'b0;
      m_rd_cnt[kr]++;
    end
    if (kw >= 0) begin
      m_wr_addr = wr_a[kw];
      m_wr_data = wr_d[kw];
      wr_ptr_m  = (kw + 1) % N;
      wr_pend[kw] = 1'b0;
      m_wr_cnt[kw]++;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic idle(input int n);
    rd_pend = '0;
    wr_pend = '0;
    drive();
    repeat (n) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] oh;
    cyc = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    mem[10'h15] = 64'hDEAD;
    for (int i = 0; i < N; i++) begin
      rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0;
    end
    rd_pend = '0; wr_pend = '0;
    drive();
    #1;
    do_reset();

    // idle after reset
    idle(10);
    check_eq("idle_rd_addr", bus.out_rd_addr_o, '0);
    check_eq("idle_rd_val",  bus.in_rd_val_o, '0);

    // single read by client 2
    rd_a[2] = 10'h15;
    rd_pend[2] = 1'b1;
    drive();
    #1;
    check_eq("c2_gnt", bus.in_rd_gnt_o, 4'b0100);
    idle(LAT + 4);

    // all four clients reading continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) rd_a[i] = AW'(i * 3 + 1);
    rd_pend = '1;
    drive();
    for (int t = 0; t < 8; t++) begin
      #1;
      oh = '0;
      oh[t % N] = 1'b1;
      check_eq("rr_order", bus.in_rd_gnt_o, oh);
      step();
      rd_pend = '1;
      drive();
    end
    idle(LAT + 4);

    // simultaneous read and two writes
    do_reset();
    rd_a[0] = 10'h7; rd_pend[0] = 1'b1;
    wr_a[1] = 10'h7; wr_d[1] = 64'hA5;
    wr_a[3] = 10'h9; wr_d[3] = 64'h5A;
    wr_pend = 4'b1010;
    drive();
    #1;
    check_eq("rw_rd_gnt", bus.in_rd_gnt_o, 4'b0001);
    check_eq("rw_wr_gnt", bus.in_wr_gnt_o, 4'b0010);
    step();
    check_eq("rw_wr_gnt2",  bus.in_wr_gnt_o, 4'b1000);
    check_eq("rw_wr_addr1", bus.out_wr_addr_o, 10'h7);
    check_eq("rw_wr_data1", bus.out_wr_data_o, 64'hA5);
    step();
    check_eq("rw_wr_en2",   bus.out_wr_en_o, 1'b1);
    check_eq("rw_wr_addr2", bus.out_wr_addr_o, 10'h9);
    check_eq("rw_wr_data2", bus.out_wr_data_o, 64'h5A);
    wr_pend = '1;
    drive();
    #1;
    check_eq("rw_wr_ptr0", bus.in_wr_gnt_o, 4'b0001);
    idle(LAT + 4);

    // reset while two reads are in flight
    do_reset();
    rd_a[0] = 10'h21; rd_a[1] = 10'h22;
    rd_pend = 4'b0011;
    drive();
    step();
    step();
    do_reset();
    idle(LAT + 4);
    rd_pend = '1; wr_pend = '1;
    drive();
    #1;
    check_eq("rst_rd_ptr", bus.in_rd_gnt_o, 4'b0001);
    check_eq("rst_wr_ptr", bus.in_wr_gnt_o, 4'b0001);
    idle(LAT + 4);

    // randomized client traffic
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!rd_pend[i] && $urandom_range(0, 9) < 4) begin
          rd_pend[i] = 1'b1;
          rd_a[i] = AW'($urandom_range(0, (1 << AW) - 1));
        end
        if (!wr_pend[i] && $urandom_range(0, 9) < 4) begin
          wr_pend[i] = 1'b1;
          wr_a[i] = AW'($urandom_range(0, (1 << AW) - 1));
          wr_d[i] = {$urandom, $urandom};
        end
      end
      drive();
      step();
    end
`ifdef DATA_TABLE_RR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      check_eq("rand_stat_rd", stat_rd_cnt[i*32 +: 32], 32'(m_rd_cnt[i]));
      check_eq("rand_stat_wr", stat_wr_cnt[i*32 +: 32], 32'(m_wr_cnt[i]));
    end
    check_eq("rand_rd_stall", stat_rd_stall, 32'(m_rd_stall));
    check_eq("rand_wr_stall", stat_wr_stall, 32'(m_wr_stall));
`endif
    idle(LAT + 4);
    check_eq("drain_empty", 64'(ret_q.size()), 64'd0);

`ifdef DATA_TABLE_RR_ARB_STATS_EN
    // three clients reading for nine cycles
    do_reset();
    rd_pend = 4'b0111;
    drive();
    for (int t = 0; t < 9; t++) begin
      step();
      rd_pend = 4'b0111;
      drive();
    end
    check_eq("stat_rd0", stat_rd_cnt[0*32 +: 32], 32'd3);
    check_eq("stat_rd1", stat_rd_cnt[1*32 +: 32], 32'd3);
    check_eq("stat_rd2", stat_rd_cnt[2*32 +: 32], 32'd3);
    check_eq("stat_rd3", stat_rd_cnt[3*32 +: 32], 32'd0);
    check_eq("stat_rd_stall", stat_rd_stall, 32'd9);
    check_eq("stat_wr_stall", stat_wr_stall, 32'd0);
    idle(LAT + 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
